// File: rtl/data_chk_pkg.sv
// -----------------------------------------------------------------------------
// data_chk_pkg
// Shared definitions for the checksum-interleaved stream (transmit multiplexer
// and receive demultiplexer).
//   DATA_W_DEF / KEEP_W_DEF / ID_W_DEF : default bus widths
//   GROUP_BEATS_DEF                    : data beats per full group
//   CHK_W_DEF                          : checksum width
//   beat_type_e                        : classification of an accepted beat
//   chk_fold()                         : keep-masked XOR fold of one data beat
// -----------------------------------------------------------------------------
package data_chk_pkg;

    localparam int DATA_W_DEF      = 512;
    localparam int KEEP_W_DEF      = 64;
    localparam int ID_W_DEF        = 6;
    localparam int GROUP_BEATS_DEF = 4;
    localparam int CHK_W_DEF       = 32;

    typedef enum logic {
        BEAT_DATA = 1'b0,
        BEAT_CHK  = 1'b1
    } beat_type_e;

    // Bytes whose enable is low contribute zero, then every CHK_W word of the
    // masked beat is XORed together. Both ends of the link must agree on this.
    function automatic logic [CHK_W_DEF-1:0] chk_fold(
        input logic [DATA_W_DEF-1:0] data,
        input logic [KEEP_W_DEF-1:0] keep
    );
        logic [DATA_W_DEF-1:0] masked;
        logic [CHK_W_DEF-1:0]  result;
        masked = '0;
        result = '0;
        for (int b = 0; b < KEEP_W_DEF; b++) begin
            masked[b*8 +: 8] = keep[b] ? data[b*8 +: 8] : 8'h00;
        end
        for (int w = 0; w < DATA_W_DEF / CHK_W_DEF; w++) begin
            result = result ^ masked[w*CHK_W_DEF +: CHK_W_DEF];
        end
        return result;
    endfunction

endpackage

// File: rtl/data_chk_fold.sv
// -----------------------------------------------------------------------------
// data_chk_fold
// Combinational keep-masked XOR fold of one beat down to a checksum word.
// Ports:
//   data  in  DATA_W  beat payload
//   keep  in  KEEP_W  byte enables (disabled bytes count as zero)
//   chk   out CHK_W   XOR of all CHK_W words of the masked payload
// DATA_W must be a multiple of CHK_W.
// -----------------------------------------------------------------------------
module data_chk_fold #(
    parameter int DATA_W = 512,
    parameter int KEEP_W = 64,
    parameter int CHK_W  = 32
) (
    input  logic [DATA_W-1:0] data,
    input  logic [KEEP_W-1:0] keep,
    output logic [CHK_W-1:0]  chk
);

    localparam int WORDS = DATA_W / CHK_W;

    logic [DATA_W-1:0] masked;

    // Zero every byte whose enable is low before folding.
    for (genvar b = 0; b < KEEP_W; b++) begin : g_mask
        assign masked[b*8 +: 8] = keep[b] ? data[b*8 +: 8] : 8'h00;
    end

    // XOR all words of the masked beat together.
    always_comb begin
        chk = '0;
        for (int w = 0; w < WORDS; w++) begin
            chk = chk ^ masked[w*CHK_W +: CHK_W];
        end
    end

endmodule

// File: rtl/data_chk_demultiplexer.sv
// -----------------------------------------------------------------------------
// data_chk_demultiplexer
// Receive side of the checksum-interleaved stream. Each group of up to
// GROUP_BEATS data beats is followed by one checksum beat. Checksum beats are
// stripped and verified; data beats are forwarded with a restored last flag.
// Ports:
//   clock, reset             rising-edge clock, async active-high reset
//   inp_data/keep/id/last    incoming beat; inp_last marks the final checksum
//   inp_valid / inp_ready    input handshake
//   out_data/keep/id/last    stripped data beat; out_last on final data beat
//   out_valid / out_ready    output handshake, full backpressure
//   chk_err                  1-cycle pulse: group checksum mismatch
//   proto_err                1-cycle pulse: checksum beat with no held data
//   grp_count, err_count     only when DATA_CHK_STATS_EN is defined
// Configuration macro: DATA_CHK_STATS_EN
// -----------------------------------------------------------------------------
module data_chk_demultiplexer
    import data_chk_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int KEEP_W      = KEEP_W_DEF,
    parameter int ID_W        = ID_W_DEF,
    parameter int GROUP_BEATS = GROUP_BEATS_DEF,
    parameter int CHK_W       = CHK_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] inp_data,
    input  logic              inp_valid,
    output logic              inp_ready,
    input  logic [KEEP_W-1:0] inp_keep,
    input  logic [ID_W-1:0]   inp_id,
    input  logic              inp_last,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [KEEP_W-1:0] out_keep,
    output logic [ID_W-1:0]   out_id,
    output logic              out_last,
    output logic              chk_err,
    output logic              proto_err
`ifdef DATA_CHK_STATS_EN
    ,
    output logic [31:0]       grp_count,
    output logic [15:0]       err_count
`endif
);

    localparam int              CNT_W    = $clog2(GROUP_BEATS + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(GROUP_BEATS);

    beat_type_e        state_q;
    beat_type_e        state_d;
    logic              accept;
    logic [CHK_W-1:0]  beat_fold;
    logic [CHK_W-1:0]  acc_q;
    logic [CHK_W-1:0]  acc_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic              hold_valid;
    logic [DATA_W-1:0] hold_data;
    logic [KEEP_W-1:0] hold_keep;
    logic [ID_W-1:0]   hold_id;

    logic              push;
    logic              push_last;
    logic              load_hold;
    logic              clear_hold;
    logic              group_done;
    logic              chk_err_d;
    logic              proto_err_d;

    data_chk_fold #(
        .DATA_W (DATA_W),
        .KEEP_W (KEEP_W),
        .CHK_W  (CHK_W)
    ) u_fold (
        .data (inp_data),
        .keep (inp_keep),
        .chk  (beat_fold)
    );

    // The output register is the only storage that can stall, so the input is
    // ready whenever it is empty or draining this cycle.
    assign inp_ready = ~out_valid | out_ready;
    assign accept    = inp_valid & inp_ready;

    // State register: BEAT_CHK means the group is full and the next accepted
    // beat must be its checksum, whatever inp_last says.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= BEAT_DATA;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    // Classify each accepted beat and decide what moves where. A data beat is
    // parked in the hold register because we only learn whether it ends the
    // packet when the following beat arrives; whatever was parked before it
    // moves on to the output register. A checksum beat flushes the parked
    // beat with the packet's last flag and closes the group.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        push        = 1'b0;
        push_last   = 1'b0;
        load_hold   = 1'b0;
        clear_hold  = 1'b0;
        group_done  = 1'b0;
        chk_err_d   = 1'b0;
        proto_err_d = 1'b0;
        if (accept) begin
            if (state_q == BEAT_CHK || inp_last) begin
                state_d    = BEAT_DATA;
                cnt_d      = '0;
                acc_d      = '0;
                clear_hold = 1'b1;
                if (hold_valid) begin
                    push       = 1'b1;
                    push_last  = inp_last;
                    group_done = 1'b1;
                    chk_err_d  = (acc_q != inp_data[CHK_W-1:0]);
                end else begin
                    proto_err_d = 1'b1;
                end
            end else begin
                load_hold = 1'b1;
                push      = hold_valid;
                acc_d     = acc_q ^ beat_fold;
                if (cnt_q != FULL_CNT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                state_d = (cnt_d == FULL_CNT) ? BEAT_CHK : BEAT_DATA;
            end
        end
    end

    // Hold register: one data beat waiting for its successor.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_keep  <= '0;
            hold_id    <= '0;
        end else if (load_hold) begin
            hold_valid <= 1'b1;
            hold_data  <= inp_data;
            hold_keep  <= inp_keep;
            hold_id    <= inp_id;
        end else if (clear_hold) begin
            hold_valid <= 1'b0;
        end
    end

    // Output register: a push may coincide with a drain, in which case the
    // register simply takes the new beat and stays valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_id    <= '0;
            out_last  <= 1'b0;
        end else if (push) begin
            out_valid <= 1'b1;
            out_data  <= hold_data;
            out_keep  <= hold_keep;
            out_id    <= hold_id;
            out_last  <= push_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Error pulses are registered so they last exactly one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chk_err   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            chk_err   <= chk_err_d;
            proto_err <= proto_err_d;
        end
    end

`ifdef DATA_CHK_STATS_EN
    // Statistics: groups checked (wrapping) and error events (saturating).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grp_count <= '0;
            err_count <= '0;
        end else begin
            if (group_done) begin
                grp_count <= grp_count + 32'd1;
            end
            if ((chk_err_d || proto_err_d) && err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
        end
    end
`else
    // Without statistics the group-completion strobe has no consumer.
    logic unused_group_done;
    assign unused_group_done = group_done;
`endif

endmodule

// File: tb/tb_data_chk_demultiplexer.sv
// -----------------------------------------------------------------------------
// tb_data_chk_demultiplexer
// Directed bench for data_chk_demultiplexer with default parameters.
// -----------------------------------------------------------------------------
module tb_data_chk_demultiplexer;

    typedef struct {
        logic [511:0] data;
        logic [63:0]  keep;
        logic [5:0]   id;
        logic         last;
    } beat_t;

    logic         clock;
    logic         reset;
    logic [511:0] inp_data;
    logic         inp_valid;
    logic         inp_ready;
    logic [63:0]  inp_keep;
    logic [5:0]   inp_id;
    logic         inp_last;
    logic [511:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_keep;
    logic [5:0]   out_id;
    logic         out_last;
    logic         chk_err;
    logic         proto_err;
`ifdef DATA_CHK_STATS_EN
    logic [31:0]  grp_count;
    logic [15:0]  err_count;
`endif

    int assertions_evaluated = 0;
    int failures             = 0;
    int chk_pulses           = 0;
    int proto_pulses         = 0;
    int valid_cycles         = 0;
    beat_t got_q[$];
    beat_t exp_q[$];

    data_chk_demultiplexer dut (
        .clock     (clock),
        .reset     (reset),
        .inp_data  (inp_data),
        .inp_valid (inp_valid),
        .inp_ready (inp_ready),
        .inp_keep  (inp_keep),
        .inp_id    (inp_id),
        .inp_last  (inp_last),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_keep  (out_keep),
        .out_id    (out_id),
        .out_last  (out_last),
        .chk_err   (chk_err),
        .proto_err (proto_err)
`ifdef DATA_CHK_STATS_EN
        ,
        .grp_count (grp_count),
        .err_count (err_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs only change just after a rising edge, so at the falling edge the
    // handshake that the next rising edge will complete is already settled.
    always @(negedge clock) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                got_q.push_back('{out_data, out_keep, out_id, out_last});
            end
            if (chk_err)   chk_pulses++;
            if (proto_err) proto_pulses++;
            if (out_valid) valid_cycles++;
        end
    end

    task automatic check_output(input string tag, input logic [511:0] observed,
                                input logic [511:0] expected);
        assertions_evaluated++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [511:0] make_data(input int n);
        logic [511:0] d;
        d = '0;
        for (int w = 0; w < 16; w++) begin
            d[w*32 +: 32] = {8'(n), 8'(w), 8'hA5, 8'(n * 3 + w)};
        end
        return d;
    endfunction

    // Byte-oriented reference: byte b lands in lane b%4 of the checksum.
    function automatic logic [31:0] bench_fold(input logic [511:0] d, input logic [63:0] k);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 64; b++) begin
            if (k[b]) r[(b % 4) * 8 +: 8] = r[(b % 4) * 8 +: 8] ^ d[b*8 +: 8];
        end
        return r;
    endfunction

    task automatic apply_stimulus(input logic [511:0] d, input logic [63:0] k,
                                  input logic [5:0] id, input logic lst);
        logic taken;
        taken     = 1'b0;
        inp_data  = d;
        inp_keep  = k;
        inp_id    = id;
        inp_last  = lst;
        inp_valid = 1'b1;
        for (int t = 0; t < 100 && !taken; t++) begin
            @(negedge clock);
            taken = inp_ready;
            @(posedge clock);
            #1;
        end
        inp_valid = 1'b0;
        inp_last  = 1'b0;
        if (!taken) check_output("send_timeout", 512'(0), 512'(1));
    endtask

    task automatic send_packet(input int n_data, input int seed, input logic [5:0] id,
                               input logic [31:0] corrupt, input logic [63:0] odd_keep);
        logic [31:0]  acc;
        logic [511:0] d;
        logic [511:0] junk;
        logic [63:0]  k;
        int           in_grp;
        acc    = '0;
        in_grp = 0;
        for (int i = 0; i < n_data; i++) begin
            d = make_data(seed + i);
            k = (i == 1) ? odd_keep : '1;
            apply_stimulus(d, k, id, 1'b0);
            acc = acc ^ bench_fold(d, k);
            exp_q.push_back('{d, k, id, (i == n_data - 1)});
            in_grp++;
            if (in_grp == 4 || i == n_data - 1) begin
                junk        = make_data(seed + 100);
                junk[31:0]  = acc ^ corrupt;
                apply_stimulus(junk, 64'h0, 6'h3F, (i == n_data - 1));
                acc    = '0;
                in_grp = 0;
            end
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_scoreboard;
        got_q.delete();
        exp_q.delete();
        chk_pulses   = 0;
        proto_pulses = 0;
        valid_cycles = 0;
    endtask

    task automatic compare_outputs(input string tag);
        int n;
        check_output({tag, "_count"}, 512'(got_q.size()), 512'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_output($sformatf("%s_data%0d", tag, i), got_q[i].data, exp_q[i].data);
            check_output($sformatf("%s_keep%0d", tag, i), 512'(got_q[i].keep), 512'(exp_q[i].keep));
            check_output($sformatf("%s_id%0d", tag, i), 512'(got_q[i].id), 512'(exp_q[i].id));
            check_output($sformatf("%s_last%0d", tag, i), 512'(got_q[i].last), 512'(exp_q[i].last));
        end
    endtask

    initial begin
        logic [511:0] d0;
        logic [511:0] d1;
        logic [511:0] c;

        reset     = 1'b1;
        inp_data  = '0;
        inp_valid = 1'b0;
        inp_keep  = '0;
        inp_id    = '0;
        inp_last  = 1'b0;
        out_ready = 1'b1;
        wait_cycles(3);

        // Reset state
        check_output("rst_out_valid", 512'(out_valid), 512'(0));
        check_output("rst_out_last",  512'(out_last),  512'(0));
        check_output("rst_out_data",  out_data,        512'(0));
        check_output("rst_chk_err",   512'(chk_err),   512'(0));
        check_output("rst_proto_err", 512'(proto_err), 512'(0));
        check_output("rst_inp_ready", 512'(inp_ready), 512'(1));
        reset = 1'b0;
        wait_cycles(2);

        // Test 1: one full group, last on the checksum, one partial-keep beat
        $display("[TB] test 1: single group");
        clear_scoreboard();
        send_packet(4, 10, 6'h11, 32'h0, 64'h00FF_0000_0000_F00F);
        wait_cycles(4);
        compare_outputs("t1");
        check_output("t1_chk_err",   512'(chk_pulses),   512'(0));
        check_output("t1_proto_err", 512'(proto_pulses), 512'(0));

        // Test 2: 9-beat packet split into 4+4+1 groups
        $display("[TB] test 2: three groups");
        clear_scoreboard();
        send_packet(9, 40, 6'h22, 32'h0, 64'hFFFF_FFFF_0000_0001);
        wait_cycles(4);
        compare_outputs("t2");
        check_output("t2_chk_err",   512'(chk_pulses),   512'(0));
        check_output("t2_proto_err", 512'(proto_pulses), 512'(0));

        // Test 3a: hand-computed group, all-ones beat with only byte 0 enabled
        // folds to 0x000000FF, second beat folds to 0x00000001 -> 0x000000FE.
        $display("[TB] test 3: hand-computed checksum");
        clear_scoreboard();
        d0 = '1;
        d1 = '0;
        d1[32] = 1'b1;
        c = make_data(7);
        c[31:0] = 32'h0000_00FE;
        apply_stimulus(d0, 64'h1, 6'h05, 1'b0);
        apply_stimulus(d1, '1, 6'h05, 1'b0);
        apply_stimulus(c, 64'h0, 6'h00, 1'b1);
        exp_q.push_back('{d0, 64'h1, 6'h05, 1'b0});
        exp_q.push_back('{d1, '1, 6'h05, 1'b1});
        wait_cycles(4);
        compare_outputs("t3a");
        check_output("t3a_chk_err", 512'(chk_pulses), 512'(0));

        // Test 3b: same group with checksum bit 0 flipped
        clear_scoreboard();
        c[31:0] = 32'h0000_00FF;
        apply_stimulus(d0, 64'h1, 6'h05, 1'b0);
        apply_stimulus(d1, '1, 6'h05, 1'b0);
        apply_stimulus(c, 64'h0, 6'h00, 1'b1);
        exp_q.push_back('{d0, 64'h1, 6'h05, 1'b0});
        exp_q.push_back('{d1, '1, 6'h05, 1'b1});
        wait_cycles(4);
        compare_outputs("t3b");
        check_output("t3b_chk_err",   512'(chk_pulses),   512'(1));
        check_output("t3b_proto_err", 512'(proto_pulses), 512'(0));

        // Test 4: checksum beat straight after reset
        $display("[TB] test 4: orphan checksum");
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        wait_cycles(1);
        clear_scoreboard();
        apply_stimulus(make_data(9), '1, 6'h01, 1'b1);
        wait_cycles(4);
        check_output("t4_proto_err",    512'(proto_pulses), 512'(1));
        check_output("t4_chk_err",      512'(chk_pulses),   512'(0));
        check_output("t4_valid_cycles", 512'(valid_cycles), 512'(0));
        check_output("t4_out_count",    512'(got_q.size()), 512'(0));

        // Test 5: sink stalls for 10 cycles while a 4+2 packet streams in
        $display("[TB] test 5: backpressure");
        clear_scoreboard();
        out_ready = 1'b0;
        fork
            send_packet(6, 50, 6'h2A, 32'h0, 64'h0F0F_0F0F_0F0F_0F0F);
            begin
                wait_cycles(5);
                check_output("t5_stall_ready", 512'(inp_ready), 512'(0));
                wait_cycles(5);
                out_ready = 1'b1;
            end
        join
        wait_cycles(4);
        compare_outputs("t5");
        check_output("t5_chk_err", 512'(chk_pulses), 512'(0));

        // Test 6: reset with hold and output registers both full
        $display("[TB] test 6: reset mid-packet");
        clear_scoreboard();
        out_ready = 1'b0;
        apply_stimulus(make_data(70), '1, 6'h06, 1'b0);
        apply_stimulus(make_data(71), '1, 6'h06, 1'b0);
        check_output("t6_pre_valid", 512'(out_valid), 512'(1));
        reset = 1'b1;
        #1;
        check_output("t6_out_valid", 512'(out_valid), 512'(0));
        check_output("t6_out_data",  out_data,        512'(0));
        check_output("t6_out_keep",  512'(out_keep),  512'(0));
        check_output("t6_out_id",    512'(out_id),    512'(0));
        check_output("t6_out_last",  512'(out_last),  512'(0));
        wait_cycles(2);
        reset     = 1'b0;
        out_ready = 1'b1;
        wait_cycles(1);
        clear_scoreboard();
        send_packet(3, 80, 6'h07, 32'h0, 64'hFFFF_0000_FFFF_0000);
        wait_cycles(4);
        compare_outputs("t6");
        check_output("t6_chk_err",   512'(chk_pulses),   512'(0));
        check_output("t6_proto_err", 512'(proto_pulses), 512'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertions_evaluated, failures);
        $finish;
    end

endmodule
